intersection_phase_scheduler: RTL and testbench

// Phase scheduler for an N-approach signalised intersection with pedestrian crossing. Arbitrates

---
 rtl/traffic_pkg.sv | 21 ++
 rtl/rr_next_picker.sv | 27 ++
 rtl/intersection_phase_scheduler.sv | 141 ++++++++++++++
 tb/tb_intersection_phase_scheduler.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared definitions for intersection lamp sequencing: phase encodings, lamp widths
// and default durations reused by the per-road light drivers.
package traffic_pkg;

    typedef enum logic [1:0] {
        ST_ALL_RED = 2'd0,
        ST_GREEN   = 2'd1,
        ST_YELLOW  = 2'd2,
        ST_WALK    = 2'd3
    } phase_state_e;

    localparam int N_APPR_DEF    = 4;
    localparam int LAMP_W        = N_APPR_DEF;
    localparam int CNT_W_DEF     = 8;
    localparam int MIN_GREEN_DEF = 10;
    localparam int MAX_GREEN_DEF = 40;
    localparam int YELLOW_DEF    = 4;
    localparam int ALL_RED_DEF   = 2;
    localparam int PED_WALK_DEF  = 8;

endpackage

// File: rtl/rr_next_picker.sv
// Round-robin successor picker: first requester after cur (wrapping), excluding cur itself.
// found_o=0 means nobody else is asking and nxt_o simply echoes cur_i.
module rr_next_picker
    import traffic_pkg::*;
#(
    parameter int N = N_APPR_DEF,
    localparam int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] cur_i,
    output logic [IDX_W-1:0] nxt_o,
    output logic             found_o
);

    always_comb begin
        nxt_o   = cur_i;
        found_o = 1'b0;
        // Walk from the far end back so the nearest successor wins.
        for (int k = N - 1; k >= 1; k--) begin
            if (req_i[(int'(cur_i) + k) % N]) begin
                nxt_o   = IDX_W'((int'(cur_i) + k) % N);
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/intersection_phase_scheduler.sv
// Intersection phase FSM: round-robin green arbitration with min/max green, yellow,
// all-red clearance and an exclusive pedestrian walk phase.
//   state      | meaning
//   ST_ALL_RED | clearance; every approach red
//   ST_GREEN   | approach cur has green
//   ST_YELLOW  | approach cur has yellow
//   ST_WALK    | pedestrian walk, every approach red
module intersection_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int N_APPR    = N_APPR_DEF,
    parameter int CNT_W     = CNT_W_DEF,
    parameter int MIN_GREEN = MIN_GREEN_DEF,
    parameter int MAX_GREEN = MAX_GREEN_DEF,
    parameter int YELLOW    = YELLOW_DEF,
    parameter int ALL_RED   = ALL_RED_DEF,
    parameter int PED_WALK  = PED_WALK_DEF,
    localparam int IDX_W    = $clog2(N_APPR)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [N_APPR-1:0] req_i,
    input  logic              ped_req_i,
    output logic [N_APPR-1:0] green_o,
    output logic [N_APPR-1:0] yellow_o,
    output logic [N_APPR-1:0] red_o,
    output logic              walk_o,
    output logic [IDX_W-1:0]  phase_idx_o
);

    localparam logic [CNT_W-1:0] AR_LAST   = CNT_W'(ALL_RED - 1);
    localparam logic [CNT_W-1:0] MING_LAST = CNT_W'(MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] MAXG_LAST = CNT_W'(MAX_GREEN - 1);
    localparam logic [CNT_W-1:0] YEL_LAST  = CNT_W'(YELLOW - 1);
    localparam logic [CNT_W-1:0] WALK_LAST = CNT_W'(PED_WALK - 1);

    phase_state_e      state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  cur_q, cur_d, nxt_q, nxt_d;
    logic              ped_pend_q, ped_pend_d;
    logic              from_yel_q, from_yel_d;
    logic [N_APPR-1:0] green_q, green_d, yellow_q, yellow_d, red_q, red_d;
    logic              walk_q, walk_d;
    logic [IDX_W-1:0]  pick_nxt;
    logic              pick_found;
    logic              other, walk_entry;

    rr_next_picker #(.N(N_APPR)) u_picker (
        .req_i  (req_i),
        .cur_i  (cur_q),
        .nxt_o  (pick_nxt),
        .found_o(pick_found)
    );

    assign other = |(req_i & ~(N_APPR'(1) << cur_q));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + CNT_W'(1);
        cur_d      = cur_q;
        nxt_d      = nxt_q;
        from_yel_d = from_yel_q;
        walk_entry = 1'b0;
        case (state_q)
            ST_ALL_RED: begin
                if (cnt_q == AR_LAST) begin
                    cnt_d = '0;
                    if (ped_pend_q && from_yel_q) begin
                        state_d    = ST_WALK;
                        walk_entry = 1'b1;
                    end else begin
                        state_d = ST_GREEN;
                        cur_d   = nxt_q;
                    end
                end
            end
            ST_GREEN: begin
                if (cnt_q == MAXG_LAST) cnt_d = cnt_q;
                if (cnt_q >= MING_LAST && (other || ped_pend_q) &&
                    (!req_i[cur_q] || cnt_q == MAXG_LAST)) begin
                    state_d = ST_YELLOW;
                    cnt_d   = '0;
                    nxt_d   = pick_found ? pick_nxt : cur_q;
                end
            end
            ST_YELLOW: begin
                if (cnt_q == YEL_LAST) begin
                    state_d    = ST_ALL_RED;
                    cnt_d      = '0;
                    from_yel_d = 1'b1;
                end
            end
            default: begin
                if (cnt_q == WALK_LAST) begin
                    state_d    = ST_ALL_RED;
                    cnt_d      = '0;
                    from_yel_d = 1'b0;
                end
            end
        endcase
        // A fresh press in the WALK-entry cycle must survive for the next cycle.
        ped_pend_d = ped_req_i | (ped_pend_q & ~walk_entry);
        green_d    = (state_d == ST_GREEN)  ? (N_APPR'(1) << cur_d) : '0;
        yellow_d   = (state_d == ST_YELLOW) ? (N_APPR'(1) << cur_d) : '0;
        red_d      = ~(green_d | yellow_d);
        walk_d     = (state_d == ST_WALK);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_ALL_RED;
            cnt_q      <= '0;
            cur_q      <= '0;
            nxt_q      <= '0;
            ped_pend_q <= 1'b0;
            from_yel_q <= 1'b0;
            green_q    <= '0;
            yellow_q   <= '0;
            red_q      <= '1;
            walk_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cur_q      <= cur_d;
            nxt_q      <= nxt_d;
            ped_pend_q <= ped_pend_d;
            from_yel_q <= from_yel_d;
            green_q    <= green_d;
            yellow_q   <= yellow_d;
            red_q      <= red_d;
            walk_q     <= walk_d;
        end
    end

    assign green_o     = green_q;
    assign yellow_o    = yellow_q;
    assign red_o       = red_q;
    assign walk_o      = walk_q;
    assign phase_idx_o = cur_q;

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Scoreboard bench: each scenario queues its hand-computed lamp-change events; a negedge
// monitor pops one per observed output change and checks cycle and lamp values.
module tb_intersection_phase_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] req = 4'b0000;
    logic       ped = 1'b0;
    logic [3:0] green, yellow, red;
    logic       walk;
    logic [1:0] idx;

    intersection_phase_scheduler dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .req_i      (req),
        .ped_req_i  (ped),
        .green_o    (green),
        .yellow_o   (yellow),
        .red_o      (red),
        .walk_o     (walk),
        .phase_idx_o(idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [3:0] g;
        logic [3:0] y;
        logic       w;
        logic [1:0] i;
    } ev_t;

    ev_t         expq[$];
    ev_t         e;
    int          errors = 0;
    int          checks = 0;
    int          edges  = 0;
    logic [10:0] prev   = 11'd0;
    logic [10:0] snap;

    // edges at a negedge equals the cycle number (cycle 0 = first edge after release)
    always @(posedge clk or posedge rst) begin
        if (rst) edges <= 0;
        else     edges <= edges + 1;
    end

    always @(negedge clk) begin
        if (rst) begin
            prev = 11'd0;
        end else begin
            checks = checks + 1;
            if (red !== ~(green | yellow) || !$onehot0(green) || !$onehot0(yellow) ||
                (walk && (green | yellow) != 4'b0000)) begin
                errors = errors + 1;
                $display("FAIL lamp_invariant cycle %0d: got g=%b y=%b r=%b w=%b", edges, green, yellow, red, walk);
            end
            snap = {green, yellow, walk, idx};
            if (snap !== prev) begin
                checks = checks + 1;
                if (expq.size() == 0) begin
                    errors = errors + 1;
                    $display("FAIL unexpected_event cycle %0d: got g=%b y=%b w=%b idx=%0d, want no change",
                             edges, green, yellow, walk, idx);
                end else begin
                    e = expq.pop_front();
                    if (e.cyc != edges || e.g !== green || e.y !== yellow || e.w !== walk || e.i !== idx) begin
                        errors = errors + 1;
                        $display("FAIL phase_event: got cycle %0d g=%b y=%b w=%b idx=%0d, want cycle %0d g=%b y=%b w=%b idx=%0d",
                                 edges, green, yellow, walk, idx, e.cyc, e.g, e.y, e.w, e.i);
                    end
                end
                prev = snap;
            end
        end
    end

    function automatic void exp_ev(input int c, input logic [3:0] g, input logic [3:0] y,
                                   input logic w, input logic [1:0] i);
        ev_t t;
        t.cyc = c; t.g = g; t.y = y; t.w = w; t.i = i;
        expq.push_back(t);
    endfunction

    task automatic do_reset(input logic [3:0] r);
        rst = 1'b1;
        req = r;
        ped = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks = checks + 1;
        if (green !== 4'b0000 || yellow !== 4'b0000 || red !== 4'b1111 || walk !== 1'b0 || idx !== 2'd0) begin
            errors = errors + 1;
            $display("FAIL reset_values: got g=%b y=%b r=%b w=%b idx=%0d, want 0000 0000 1111 0 0",
                     green, yellow, red, walk, idx);
        end
        #1 rst = 1'b0;
    endtask

    task automatic run_until(input int c);
        while (edges < c) @(negedge clk);
    endtask

    task automatic end_test(input string name);
        #1;
        checks = checks + 1;
        if (expq.size() != 0) begin
            errors = errors + 1;
            $display("FAIL %s_missing: got %0d events still pending (next at cycle %0d), want 0",
                     name, expq.size(), expq[0].cyc);
            expq.delete();
        end
    endtask

    initial begin
        // 1: no demand -> green rests on approach 0
        do_reset(4'b0000);
        exp_ev(2, 4'b0001, 4'b0000, 1'b0, 2'd0);
        run_until(502);
        end_test("idle");

        // 2: demand on approach 2 only
        do_reset(4'b0100);
        exp_ev(2,  4'b0001, 4'b0000, 1'b0, 2'd0);
        exp_ev(12, 4'b0000, 4'b0001, 1'b0, 2'd0);
        exp_ev(16, 4'b0000, 4'b0000, 1'b0, 2'd0);
        exp_ev(18, 4'b0100, 4'b0000, 1'b0, 2'd2);
        run_until(60);
        end_test("single_req");

        // 3: contested, held demand -> MAX_GREEN cap
        do_reset(4'b0011);
        exp_ev(2,  4'b0001, 4'b0000, 1'b0, 2'd0);
        exp_ev(42, 4'b0000, 4'b0001, 1'b0, 2'd0);
        exp_ev(46, 4'b0000, 4'b0000, 1'b0, 2'd0);
        exp_ev(48, 4'b0010, 4'b0000, 1'b0, 2'd1);
        exp_ev(88, 4'b0000, 4'b0010, 1'b0, 2'd1);
        exp_ev(92, 4'b0000, 4'b0000, 1'b0, 2'd1);
        exp_ev(94, 4'b0001, 4'b0000, 1'b0, 2'd0);
        run_until(100);
        end_test("max_green");

        // 4: round-robin 1 -> 3 -> 1
        do_reset(4'b1010);
        exp_ev(2,   4'b0001, 4'b0000, 1'b0, 2'd0);
        exp_ev(12,  4'b0000, 4'b0001, 1'b0, 2'd0);
        exp_ev(16,  4'b0000, 4'b0000, 1'b0, 2'd0);
        exp_ev(18,  4'b0010, 4'b0000, 1'b0, 2'd1);
        exp_ev(58,  4'b0000, 4'b0010, 1'b0, 2'd1);
        exp_ev(62,  4'b0000, 4'b0000, 1'b0, 2'd1);
        exp_ev(64,  4'b1000, 4'b0000, 1'b0, 2'd3);
        exp_ev(104, 4'b0000, 4'b1000, 1'b0, 2'd3);
        exp_ev(108, 4'b0000, 4'b0000, 1'b0, 2'd3);
        exp_ev(110, 4'b0010, 4'b0000, 1'b0, 2'd1);
        run_until(120);
        end_test("round_robin");

        // 5: ped pulse while green rests (saturated) on approach 2
        do_reset(4'b0100);
        exp_ev(2,  4'b0001, 4'b0000, 1'b0, 2'd0);
        exp_ev(12, 4'b0000, 4'b0001, 1'b0, 2'd0);
        exp_ev(16, 4'b0000, 4'b0000, 1'b0, 2'd0);
        exp_ev(18, 4'b0100, 4'b0000, 1'b0, 2'd2);
        exp_ev(72, 4'b0000, 4'b0100, 1'b0, 2'd2);
        exp_ev(76, 4'b0000, 4'b0000, 1'b0, 2'd2);
        exp_ev(78, 4'b0000, 4'b0000, 1'b1, 2'd2);
        exp_ev(86, 4'b0000, 4'b0000, 1'b0, 2'd2);
        exp_ev(88, 4'b0100, 4'b0000, 1'b0, 2'd2);
        run_until(70);
        ped = 1'b1;
        run_until(71);
        ped = 1'b0;
        run_until(100);
        end_test("ped_walk");

        // 6: async reset mid-YELLOW with ped pending; the press must be discarded
        do_reset(4'b0100);
        exp_ev(2,  4'b0001, 4'b0000, 1'b0, 2'd0);
        exp_ev(12, 4'b0000, 4'b0001, 1'b0, 2'd0);
        run_until(5);
        ped = 1'b1;
        run_until(6);
        ped = 1'b0;
        run_until(13);
        end_test("pre_reset");
        rst = 1'b1;
        #1;
        checks = checks + 1;
        if (green !== 4'b0000 || yellow !== 4'b0000 || red !== 4'b1111 || walk !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL async_reset: got g=%b y=%b r=%b w=%b, want 0000 0000 1111 0",
                     green, yellow, red, walk);
        end
        do_reset(4'b0000);
        exp_ev(2, 4'b0001, 4'b0000, 1'b0, 2'd0);
        run_until(60);
        end_test("post_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
